bcd_seq_converter: RTL and testbench

//   Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/bcd_seq_converter.sv | 113 +++++++++++
 tb/tb_bcd_seq_converter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// The last result stays on bcd_out/ovf while the next conversion runs.
module bcd_seq_converter #(
  parameter int IN_W   = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int          SW    = 4*DIGITS + 4;
  localparam int          CW    = $clog2(IN_W + 1);
  localparam logic [31:0] LIMIT = 32'(10**DIGITS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_r;
  logic [IN_W-1:0]     shreg_r;
  logic [SW-1:0]       scratch_r;
  logic [CW-1:0]       cnt_r;
  logic                ovf_next_r;
  logic                busy_r;
  logic                done_r;
  logic [4*DIGITS-1:0] bcd_r;
  logic                ovf_r;

  logic [SW-1:0]       adj_s;
  logic [SW+IN_W-1:0]  nxt_s;

  // Nibble correction ahead of the shift; the guard nibble is corrected too.
  function automatic logic [SW-1:0] add3_nibbles(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = v;
    for (int i = 0; i < SW/4; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Corrected scratch concatenated with the shift register, shifted left one bit.
  always_comb begin
    adj_s = add3_nibbles(scratch_r);
    nxt_s = {adj_s, shreg_r} << 1'b1;
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      scratch_r  <= '0;
      cnt_r      <= '0;
      ovf_next_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bcd_r      <= '0;
      ovf_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            shreg_r    <= bin_in;
            scratch_r  <= '0;
            cnt_r      <= CW'(IN_W);
            ovf_next_r <= (32'(bin_in) >= LIMIT);
            busy_r     <= 1'b1;
            state_r    <= SHIFT;
          end else begin
            state_r    <= IDLE;
          end
        end
        SHIFT: begin
          scratch_r <= nxt_s[SW+IN_W-1:IN_W];
          shreg_r   <= nxt_s[IN_W-1:0];
          cnt_r     <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            bcd_r   <= nxt_s[IN_W +: 4*DIGITS];
            ovf_r   <= ovf_next_r;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= SHIFT;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bcd_out = bcd_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: directed cases plus randomized traffic, checked every
// cycle against a decimal-arithmetic reference model.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] bin_in = 13'd0;
  logic        busy, done, ovf;
  logic [15:0] bcd_out;

  logic        start2 = 1'b0;
  logic [12:0] bin2 = 13'd0;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  bcd_seq_converter #(.IN_W(13), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
  );

  bcd_seq_converter #(.IN_W(13), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .ovf(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned p;
    r = 16'h0000;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: a conversion finishes 13 edges after acceptance with the decimal digits.
  int          remain;
  logic [12:0] m_val;
  logic        m_busy, m_done, m_ovf;
  logic [15:0] m_bcd;

  always @(posedge clk) begin
    if (!rst_n) begin
      remain <= 0; m_val <= 13'd0; m_busy <= 1'b0; m_done <= 1'b0;
      m_bcd <= 16'h0000; m_ovf <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (remain == 0) begin
        if (start) begin
          m_val <= bin_in; remain <= 13; m_busy <= 1'b1;
        end
      end else if (remain == 1) begin
        remain <= 0; m_busy <= 1'b0; m_done <= 1'b1;
        m_bcd <= to_bcd(32'(m_val)); m_ovf <= (32'(m_val) >= 10000);
      end else begin
        remain <= remain - 1;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  // Start a conversion and wait for done; reports busy cycles and done cycle number.
  task automatic conv(input logic [12:0] v, input bit noise, output int nbusy, output int dcyc);
    bit seen;
    seen = 1'b0;
    nbusy = 0;
    dcyc = 0;
    @(negedge clk);
    start = 1'b1;
    bin_in = v;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
        break;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        bin_in = 13'($urandom_range(0, 8191));
      end
    end
    start = 1'b0;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: got no done expected done for value %0d", v);
    end
  endtask

  int nb, d0, d1, d2;
  logic [15:0] exp_lit;

  initial begin
    // Reset two cycles and check the cleared state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'h0000);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Pin the model's digit function to hand-computed values.
    chk("model_510", 32'(to_bcd(510)), 32'h0510);
    chk("model_8191", 32'(to_bcd(8191)), 32'h8191);

    conv(13'd510, 1'b0, nb, d0);
    chk("busy_len", 32'(nb), 32'd13);
    chk("conv_510", 32'(bcd_out), 32'h0510);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("hold_510", 32'(bcd_out), 32'h0510);

    conv(13'd0, 1'b0, nb, d0);    chk("conv_0", 32'(bcd_out), 32'h0000);
    conv(13'd8191, 1'b0, nb, d0); chk("conv_8191", 32'(bcd_out), 32'h8191);
    chk("ovf_8191", 32'(ovf), 32'd0);
    conv(13'd999, 1'b0, nb, d0);  chk("conv_999", 32'(bcd_out), 32'h0999);

    // Start pulses while busy with bin_in=77 are ignored.
    @(negedge clk);
    start = 1'b1; bin_in = 13'd4321;
    @(negedge clk);
    bin_in = 13'd77;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = ~start;
      if (done) break;
    end
    start = 1'b0;
    chk("busy_ignore", 32'(bcd_out), 32'h4321);
    @(negedge clk);
    chk("not_queued", 32'(busy), 32'd0);

    // Back-to-back conversions started in each done cycle.
    conv(13'd9, 1'b0, nb, d0);
    chk("b2b_9", 32'(bcd_out), 32'h0009);
    start = 1'b1; bin_in = 13'd10;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); start = 1'b0;
      if (done) begin d1 = cyc; break; end
    end
    chk("b2b_10", 32'(bcd_out), 32'h0010);
    start = 1'b1; bin_in = 13'd99;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); start = 1'b0;
      if (done) begin d2 = cyc; break; end
    end
    chk("b2b_99", 32'(bcd_out), 32'h0099);
    chk("b2b_gap1", 32'(d1 - d0), 32'd14);
    chk("b2b_gap2", 32'(d2 - d1), 32'd14);

    // Reset at shift cycle 6 of 1234 aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; bin_in = 13'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) nb++;
    end
    chk("abort_no_done", 32'(nb), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'h0000);

    // Two-digit instance overflows on 123 and keeps the low digits.
    @(negedge clk);
    start2 = 1'b1; bin2 = 13'd123;
    d0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); start2 = 1'b0;
      if (done2) begin d0 = 1; break; end
    end
    chk("d2_done", 32'(d0), 32'd1);
    chk("d2_bcd_123", 32'(bcd2), 32'h23);
    chk("d2_ovf_123", 32'(ovf2), 32'd1);
    @(negedge clk);
    start2 = 1'b1; bin2 = 13'd45;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); start2 = 1'b0;
      if (done2) break;
    end
    chk("d2_bcd_45", 32'(bcd2), 32'h45);
    chk("d2_ovf_45", 32'(ovf2), 32'd0);

    // Randomized traffic with noise on start/bin_in during conversions.
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      exp_lit = 16'h0000;
      conv(13'($urandom_range(0, 8191)), 1'b1, nb, d0);
      for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
